// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : alu_sequencer                                                   |
// | Desc   : FIFO-buffered command sequencer driving an external ALU, with a |
// |          valid/ready response channel. Define ALU_SEQ_CHECK_EN to add   |
// |          result self-checking (rsp_mismatch, err_sticky).                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int ALU_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int ALU_LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ALU_WIDTH-1:0] req_a,
    input  logic [ALU_WIDTH-1:0] req_b,
    input  logic [1:0]           req_op,
    output logic [ALU_WIDTH-1:0] alu_a,
    output logic [ALU_WIDTH-1:0] alu_b,
    output logic [1:0]           alu_op,
    input  logic [ALU_WIDTH-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_WIDTH-1:0] rsp_data,
    output logic [1:0]           rsp_op,
    output logic                 busy,
    output logic [15:0]          op_count
`ifdef ALU_SEQ_CHECK_EN
    ,
    output logic                 rsp_mismatch,
    output logic                 err_sticky
`endif
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam int             c_lw   = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);
    localparam logic [c_lw-1:0] c_lat = c_lw'(ALU_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [ALU_WIDTH-1:0] r_fifo_a  [DEPTH];
    logic [ALU_WIDTH-1:0] r_fifo_b  [DEPTH];
    logic [1:0]           r_fifo_op [DEPTH];
    logic [c_aw-1:0]      r_wptr;
    logic [c_aw-1:0]      r_rptr;
    logic [c_aw:0]        r_count;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_lw-1:0]      r_lat_cnt;
    logic [ALU_WIDTH-1:0] r_alu_a;
    logic [ALU_WIDTH-1:0] r_alu_b;
    logic [1:0]           r_alu_op;
    logic                 r_rsp_valid;
    logic [ALU_WIDTH-1:0] r_rsp_data;
    logic [1:0]           r_rsp_op;
    logic [15:0]          r_op_count;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_capture;
    logic w_done;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign req_ready = (r_count != c_full);
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wptr]  <= req_a;
            r_fifo_b[r_wptr]  <= req_b;
            r_fifo_op[r_wptr] <= req_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_lat_cnt == c_lat) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_done = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Every pop issues the head command to the ALU on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
            r_op_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_alu_a   <= r_fifo_a[r_rptr];
                r_alu_b   <= r_fifo_b[r_rptr];
                r_alu_op  <= r_fifo_op[r_rptr];
                r_lat_cnt <= '0;
            end else if (r_state == S_EXEC) begin
                r_lat_cnt <= r_lat_cnt + c_lw'(1);
            end
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= alu_result;
                r_rsp_op    <= r_alu_op;
            end else if (w_done) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_done) r_op_count <= r_op_count + 16'd1;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_rsp_op;
    assign op_count  = r_op_count;
    assign busy      = (r_state != S_IDLE) || !w_empty;

`ifdef ALU_SEQ_CHECK_EN
    logic [ALU_WIDTH-1:0] w_expected;
    logic                 w_bad;
    logic                 r_rsp_mismatch;
    logic                 r_err_sticky;

    always_comb begin
        w_expected = '0;
        case (r_alu_op)
            2'b00:   w_expected = r_alu_a + r_alu_b;
            2'b01:   w_expected = r_alu_a - r_alu_b;
            2'b10:   w_expected = r_alu_a & r_alu_b;
            default: w_expected = r_alu_a | r_alu_b;
        endcase
    end

    assign w_bad = (alu_result != w_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_mismatch <= 1'b0;
            r_err_sticky   <= 1'b0;
        end else if (w_capture) begin
            r_rsp_mismatch <= w_bad;
            if (w_bad) r_err_sticky <= 1'b1;
        end
    end

    assign rsp_mismatch = r_rsp_mismatch;
    assign err_sticky   = r_err_sticky;
`endif

endmodule
`default_nettype wire
